egress: RTL and testbench
=========================

EGRESS -- requirements
Module: egress

Interface
- REQ-001: Parameter PACKET_XFER_LEN, default 32, width in bits of each input packet word and of the output record.
- REQ-002: Parameter BUFFER_LEN, default 1024, depth of the record FIFO in records; power of two, at least 2.
- REQ-003: clk  input  1  single clock; all state changes on its rising edge.
- REQ-004: reset  input  1  asynchronous, active-low reset; reset asserted (0) clears all state immediately.
- REQ-005: write_en  input  1  high for exactly the cycle in which word 0 (header) of a new packet is on data_in.
- REQ-006: data_in  input  PACKET_XFER_LEN  packet word stream, one word per cycle.
- REQ-007: read_en  input  1  software read request; a rising edge requests one record.
- REQ-008: counter  input  32  global time-slot counter; reserved, ignored by this block.
- REQ-009: data_out  output  PACKET_XFER_LEN  last record popped from the FIFO.
- REQ-010: data_valid  output  1  one-cycle pulse marking data_out as freshly updated.
- REQ-011: buffer_empty  output  1  high when the FIFO holds zero records.
- REQ-012: buffer_full  output  1  high when the FIFO holds BUFFER_LEN records.

Function
- REQ-013: Packet layout, word index k counted from the write_en cycle (k=0):
  - k=0: len = data_in[31:24] (bytes), dest = data_in[15:8].
  - k=2: src = data_in[15:8].
  - k=4: start time.
  - k=5: end time.
  - k=1, k=3 and k>=6 (payload) are ignored.
- REQ-014: Capture state machine: IDLE -> (write_en) CAPTURE; the word counter advances each cycle in CAPTURE.
  - After word 5 is captured, the FSM returns to IDLE.
  - write_en seen in any state restarts capture at k=0; a partially captured packet is discarded.
- REQ-015: Record format, built when word 5 is captured:
  - [31:30] = dest[1:0]
  - [29:28] = src[1:0]
  - [27:24] = len[5:2] (length in 32-bit words, truncated to 4 bits)
  - [23:0] = (end - start) modulo 2^24
- REQ-016: The record is pushed into the FIFO on the clock edge following capture of word 5; if the FIFO is full, the record is dropped and FIFO contents are unchanged.
- REQ-017: A read is accepted on the clock edge where read_en=1 and read_en was 0 on the previous edge.
  - Holding read_en high yields exactly one read.
- REQ-018: Accepted read with FIFO non-empty: on that same edge, pop the head record into data_out and set data_valid=1.
  - data_valid returns to 0 on the next edge; latency is 1 cycle.
- REQ-019: Accepted read with FIFO empty: data_valid stays 0 and data_out is unchanged.
- REQ-020: data_out holds its value until the next successful pop.
- REQ-021: A push and a pop on the same edge both take effect; occupancy is unchanged and FIFO order is preserved.
- REQ-022: FIFO order is strict first-in first-out; read and write pointers wrap modulo BUFFER_LEN.
- REQ-023: buffer_empty and buffer_full are decoded from the registered occupancy count (0..BUFFER_LEN).

Reset
- REQ-024: While reset=0:
  - FIFO is emptied (pointers and count = 0).
  - FSM goes to IDLE.
  - data_out=0, data_valid=0, buffer_empty=1, buffer_full=0.
  - The read_en edge-detect history is cleared to 0.
- REQ-025: Reset asserted mid-packet or mid-read discards all partial state; the first write_en after release starts a clean capture.

Verification
- REQ-026: Packet A (word0 len=40/dest=2, word2 src=3, start=5, end=12), then packet B (len=24/dest=2, src=1, start=3, end=19), then a read_en rising edge -> data_valid pulse 1 cycle later with data_out=0xBA000007; buffer_empty=0.
- REQ-027: Packet C (same as A) written; then read_en pulsed in the same cycle as the next packet's write_en -> data_out=0x96000010 (packet B), data_valid pulses once, and the packet in progress still enqueues.
- REQ-028: read_en held high for 5 cycles with 2 records stored -> exactly one pop; second record remains.
- REQ-029: Read with FIFO empty -> data_valid stays 0, data_out unchanged, buffer_empty=1.
- REQ-030: Fill BUFFER_LEN records -> buffer_full=1; the next packet is dropped; draining all records returns them in order; pointers wrap correctly.
- REQ-031: Assert reset during word 3 of a packet -> all outputs at reset values; after release a full packet produces exactly one correct record.

Source files
------------

// File: rtl/egress.sv
// Egress record builder: captures header/timing words from each packet, packs a
// 32-bit record into a FIFO, and hands records to software one per read_en rising edge.
module egress #(
  parameter int PACKET_XFER_LEN = 32,
  parameter int BUFFER_LEN      = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write_en,
  input  logic [PACKET_XFER_LEN-1:0] data_in,
  input  logic                       read_en,
  input  logic [31:0]                counter,
  output logic [PACKET_XFER_LEN-1:0] data_out,
  output logic                       data_valid,
  output logic                       buffer_empty,
  output logic                       buffer_full
);

  localparam int AW = $clog2(BUFFER_LEN);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(BUFFER_LEN);

  typedef enum logic {IDLE, CAPTURE} state_e;

  state_e                     state_q, state_d;
  logic [2:0]                 k_q, k_d;
  logic [3:0]                 len_q, len_d;
  logic [1:0]                 dest_q, dest_d, src_q, src_d;
  logic [23:0]                start_q, start_d;
  logic [PACKET_XFER_LEN-1:0] rec_q, rec_d;
  logic                       push_q, push_d;
  logic                       rd_prev_q;
  logic [AW-1:0]              rptr_q, wptr_q;
  logic [AW:0]                cnt_q, cnt_d;
  logic [PACKET_XFER_LEN-1:0] dout_q;
  logic                       dv_q;
  logic [PACKET_XFER_LEN-1:0] mem_q [BUFFER_LEN];

  logic [23:0] span;
  logic        rd_acc, do_push, do_pop;
  logic        unused_ok;

  // counter is reserved; only some header bits carry fields
  assign unused_ok = ^{counter, data_in};

  assign span = data_in[23:0] - start_q;

  // Capture FSM: write_en always restarts at word 0, dropping any partial packet
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    len_d   = len_q;
    dest_d  = dest_q;
    src_d   = src_q;
    start_d = start_q;
    rec_d   = rec_q;
    push_d  = 1'b0;
    if (write_en) begin
      len_d   = data_in[29:26];
      dest_d  = data_in[9:8];
      state_d = CAPTURE;
      k_d     = 3'd1;
    end else if (state_q == CAPTURE) begin
      k_d = k_q + 3'd1;
      case (k_q)
        3'd2: src_d   = data_in[9:8];
        3'd4: start_d = data_in[23:0];
        3'd5: begin
          rec_d        = '0;
          rec_d[31:0]  = {dest_q, src_q, len_q, span};
          push_d       = 1'b1;
          state_d      = IDLE;
          k_d          = 3'd0;
        end
        default: ;
      endcase
    end
  end

  assign rd_acc  = read_en && !rd_prev_q;
  assign do_push = push_q && !buffer_full;
  assign do_pop  = rd_acc && !buffer_empty;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      len_q     <= '0;
      dest_q    <= '0;
      src_q     <= '0;
      start_q   <= '0;
      rec_q     <= '0;
      push_q    <= 1'b0;
      rd_prev_q <= 1'b0;
      rptr_q    <= '0;
      wptr_q    <= '0;
      cnt_q     <= '0;
      dout_q    <= '0;
      dv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      len_q     <= len_d;
      dest_q    <= dest_d;
      src_q     <= src_d;
      start_q   <= start_d;
      rec_q     <= rec_d;
      push_q    <= push_d;
      rd_prev_q <= read_en;
      cnt_q     <= cnt_d;
      dv_q      <= do_pop;
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
        dout_q <= mem_q[rptr_q];
      end
    end
  end

  // Storage needs no reset; occupancy and pointers define what is live
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= rec_q;
  end

  assign data_out     = dout_q;
  assign data_valid   = dv_q;
  assign buffer_empty = (cnt_q == '0);
  assign buffer_full  = (cnt_q == FULL_CNT);

endmodule

// File: tb/tb_egress.sv
// Directed bench for egress with a queue scoreboard of expected records.
module tb_egress;
  localparam int W   = 32;
  localparam int BUF = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         write_en;
  logic [W-1:0] data_in;
  logic         read_en;
  logic [31:0]  counter;
  logic [W-1:0] data_out;
  logic         data_valid, buffer_empty, buffer_full;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  logic [31:0] last_out = '0;

  egress #(.PACKET_XFER_LEN(W), .BUFFER_LEN(BUF)) dut (
    .clk(clk), .reset(reset), .write_en(write_en), .data_in(data_in),
    .read_en(read_en), .counter(counter), .data_out(data_out),
    .data_valid(data_valid), .buffer_empty(buffer_empty), .buffer_full(buffer_full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkrec(input logic [7:0] len, input logic [7:0] dest,
                                        input logic [7:0] src, input logic [31:0] st,
                                        input logic [31:0] en);
    logic [31:0] d;
    d = en - st;
    return {dest[1:0], src[1:0], len[5:2], d[23:0]};
  endfunction

  // Six words; optional read_en pulse alongside word 0.
  task automatic send_pkt(input logic [7:0] len, input logic [7:0] dest, input logic [7:0] src,
                          input logic [31:0] st, input logic [31:0] en, input bit rd0);
    logic [31:0] exp;
    exp = '0;
    if (rd0) begin
      exp = q.pop_front();
      last_out = exp;
    end
    if (q.size() < BUF) q.push_back(mkrec(len, dest, src, st, en));
    write_en = 1'b1;
    read_en  = rd0;
    data_in  = {len, 8'($urandom), dest, 8'($urandom)};
    tick();
    write_en = 1'b0;
    if (rd0) begin
      chk("rd_with_wr_valid", 32'(data_valid), 32'd1);
      chk("rd_with_wr_data", data_out, exp);
    end
    read_en = 1'b0;
    data_in = $urandom;
    tick();
    if (rd0) chk("rd_with_wr_pulse", 32'(data_valid), 32'd0);
    data_in = {16'($urandom), src, 8'($urandom)};
    tick();
    data_in = $urandom;
    tick();
    data_in = st;
    tick();
    data_in = en;
    tick();
    data_in = $urandom;
  endtask

  task automatic do_read(input string tag);
    logic [31:0] exp;
    read_en = 1'b1;
    if (q.size() > 0) begin
      exp = q.pop_front();
      last_out = exp;
      tick();
      chk({tag, "_valid"}, 32'(data_valid), 32'd1);
      chk({tag, "_data"}, data_out, exp);
    end else begin
      tick();
      chk({tag, "_novalid"}, 32'(data_valid), 32'd0);
      chk({tag, "_hold"}, data_out, last_out);
    end
    read_en = 1'b0;
    tick();
    chk({tag, "_drop"}, 32'(data_valid), 32'd0);
  endtask

  initial begin
    int pulses;
    reset = 1'b0; write_en = 1'b0; read_en = 1'b0; data_in = '0; counter = '0;
    repeat (3) tick();
    chk("rst_dout", data_out, 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_empty", 32'(buffer_empty), 32'd1);
    chk("rst_full", 32'(buffer_full), 32'd0);
    reset = 1'b1;
    tick();

    // A then B, then read A
    send_pkt(8'd40, 8'd2, 8'd3, 32'd5, 32'd12, 1'b0);
    send_pkt(8'd24, 8'd2, 8'd1, 32'd3, 32'd19, 1'b0);
    tick();
    do_read("readA");
    chk("readA_const", data_out, 32'hBA000007);
    chk("readA_empty", 32'(buffer_empty), 32'd0);

    // C, then D with a read coinciding with its write_en
    send_pkt(8'd40, 8'd2, 8'd3, 32'd5, 32'd12, 1'b0);
    send_pkt(8'd100, 8'd1, 8'd2, 32'hFFFF_FFF0, 32'h0000_0010, 1'b1);
    chk("readB_const", data_out, 32'h96000010);
    tick();

    // Held read_en: one pop only
    read_en = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (data_valid) pulses++;
    end
    read_en = 1'b0;
    last_out = q.pop_front();
    chk("held_pulses", 32'(pulses), 32'd1);
    chk("held_data", data_out, last_out);
    tick();
    chk("held_remaining", 32'(buffer_empty), 32'd0);
    do_read("readD");
    do_read("empty_rd");
    chk("empty_flag", 32'(buffer_empty), 32'd1);

    // Fill across the pointer wrap, overflow one, drain in order
    for (int i = 0; i < BUF; i++)
      send_pkt(8'($urandom), 8'($urandom), 8'($urandom), $urandom, $urandom, 1'b0);
    tick();
    chk("full_flag", 32'(buffer_full), 32'd1);
    send_pkt(8'hFC, 8'h3, 8'h3, 32'd0, 32'h00AB_CDEF, 1'b0);
    tick();
    chk("full_after_drop", 32'(buffer_full), 32'd1);
    for (int i = 0; i < BUF; i++) do_read("drain");
    chk("drained_empty", 32'(buffer_empty), 32'd1);
    chk("drained_notfull", 32'(buffer_full), 32'd0);

    // Reset during word 3 of a packet with one record stored
    send_pkt(8'd8, 8'd1, 8'd1, 32'd1, 32'd2, 1'b0);
    tick();
    write_en = 1'b1; data_in = {8'd60, 8'd0, 8'd3, 8'd0};
    tick();
    write_en = 1'b0; data_in = $urandom;
    tick();
    data_in = 32'h0000_0200;
    tick();
    data_in = $urandom;
    reset = 1'b0;
    #1;
    q.delete();
    last_out = '0;
    chk("midrst_dout", data_out, 32'd0);
    chk("midrst_valid", 32'(data_valid), 32'd0);
    chk("midrst_empty", 32'(buffer_empty), 32'd1);
    chk("midrst_full", 32'(buffer_full), 32'd0);
    tick();
    reset = 1'b1;
    data_in = 32'h0000_0005;
    repeat (2) tick();
    send_pkt(8'd16, 8'd3, 8'd2, 32'd100, 32'd150, 1'b0);
    repeat (2) tick();
    do_read("post_rst");
    chk("post_rst_empty", 32'(buffer_empty), 32'd1);
    do_read("post_rst_none");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
